// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB command master and its wait counter.
package apb_master_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_t;

  // Counter must hold TIMEOUT itself; keep at least one bit when the timeout is disabled.
  function automatic int tmo_cnt_w(input int tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/apb_mst_tmo.sv
// Saturating ACCESS wait-state counter; flags expiry once the count equals TIMEOUT.
module apb_mst_tmo
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = tmo_cnt_w(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge pclk) begin
    if (!presetn)             cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator: valid/ready command in, APB transfer out,
// read data and error/timeout status returned on a valid/ready response stream.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_tmo,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_mst_state_t state;
  logic           accept;
  logic           tmo_clr;
  logic           tmo_inc;
  logic           tmo_expired;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // Counting the SETUP cycle makes the count equal the current ACCESS cycle
  // number, so expiry lines up with the TIMEOUT-th ACCESS cycle.
  assign tmo_clr = accept;
  assign tmo_inc = (state == ST_SETUP) || ((state == ST_ACCESS) && !pready);

  apb_mst_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pwrite  <= req_write;
            paddr   <= req_addr;
            pwdata  <= req_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready takes priority over a simultaneous expiry.
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            rsp_tmo   <= 1'b0;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= ST_RESP;
          end else if (tmo_expired) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_tmo   <= 1'b1;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed plus randomized bench for apb_cmd_master against a transaction-level model.
module tb_apb_cmd_master;

  localparam int AW  = 12;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err, rsp_tmo;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    int            waits;
    logic          serr;
  } txn_t;

  apb_cmd_master #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model: a transfer ends at the first ready cycle or after TMO wait cycles.
  task automatic run_txn(input txn_t t, input int bp, input bit has_nxt, input txn_t nxt);
    bit          tmo;
    int          nacc;
    logic [31:0] exp_rd;
    logic        exp_err;
    tmo     = (t.waits >= TMO);
    nacc    = tmo ? TMO : t.waits + 1;
    exp_rd  = (tmo || t.wr) ? 32'h0 : t.rdata;
    exp_err = tmo ? 1'b1 : t.serr;

    @(negedge pclk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_psel", psel, 0);
    req_valid = 1'b1; req_write = t.wr; req_addr = t.addr; req_wdata = t.wdata;
    pready = 1'($urandom); pslverr = 1'($urandom);

    @(negedge pclk);
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, t.addr);
    chk("setup_pwrite", pwrite, t.wr);
    chk("setup_pwdata", pwdata, t.wdata);
    chk("setup_req_ready", req_ready, 0);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    pready = 1'($urandom); pslverr = 1'($urandom);

    for (int k = 1; k <= nacc; k++) begin
      @(negedge pclk);
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, t.addr);
      chk("access_pwdata", pwdata, t.wdata);
      chk("access_rsp_valid", rsp_valid, 0);
      pready  = (k == t.waits + 1);
      pslverr = pready ? t.serr : 1'($urandom);
      prdata  = pready ? t.rdata : $urandom;
    end

    @(negedge pclk);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, exp_err);
    chk("resp_tmo", rsp_tmo, tmo);
    chk("resp_req_ready", req_ready, 0);
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    rsp_ready = (bp == 0);
    if (has_nxt) begin
      req_valid = 1'b1; req_write = nxt.wr; req_addr = nxt.addr; req_wdata = nxt.wdata;
    end

    for (int b = 1; b <= bp; b++) begin
      @(negedge pclk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, exp_rd);
      chk("bp_rsp_err", rsp_err, exp_err);
      chk("bp_rsp_tmo", rsp_tmo, tmo);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_psel", psel, 0);
      pready = 1'($urandom); pslverr = 1'($urandom);
      rsp_ready = (b == bp);
    end
  endtask

  txn_t t, n, none;

  initial begin
    presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; prdata = 32'hDEAD_BEEF; pready = 1'b1; pslverr = 1'b1;
    none = '{wr: 1'b0, addr: '0, wdata: '0, rdata: '0, waits: 0, serr: 1'b0};
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_tmo", rsp_tmo, 0);

    // zero-wait write, zero-wait read, wait states with slave error
    t = '{wr: 1'b1, addr: 12'h000, wdata: 32'hA5, rdata: 32'h1234, waits: 0, serr: 1'b0};
    run_txn(t, 0, 1'b0, none);
    t = '{wr: 1'b0, addr: 12'h050, wdata: 32'h0, rdata: 32'h3C, waits: 0, serr: 1'b0};
    run_txn(t, 0, 1'b0, none);
    t = '{wr: 1'b0, addr: 12'h124, wdata: 32'h0, rdata: 32'h77, waits: 3, serr: 1'b1};
    run_txn(t, 0, 1'b0, none);

    // stuck slave times out; ready in the last allowed cycle wins
    t = '{wr: 1'b0, addr: 12'h200, wdata: 32'h0, rdata: 32'h55, waits: 100, serr: 1'b0};
    run_txn(t, 0, 1'b0, none);
    t = '{wr: 1'b0, addr: 12'h204, wdata: 32'h0, rdata: 32'h66, waits: TMO - 1, serr: 1'b0};
    run_txn(t, 0, 1'b0, none);

    // backpressure with next command waiting, then that command back-to-back
    t = '{wr: 1'b0, addr: 12'h3F3, wdata: 32'h0, rdata: 32'hCAFE_F00D, waits: 1, serr: 1'b0};
    n = '{wr: 1'b1, addr: 12'h0A1, wdata: 32'h1357_9BDF, rdata: 32'h0, waits: 0, serr: 1'b1};
    run_txn(t, 5, 1'b1, n);
    run_txn(n, 0, 1'b0, none);

    // reset during ACCESS abandons the transfer
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h777; req_wdata = 32'hFFFF_0000;
    @(negedge pclk);
    req_valid = 1'b0; pready = 1'b0;
    @(negedge pclk);
    chk("mid_access_penable", penable, 1);
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_paddr", paddr, 0);
    chk("midrst_pwdata", pwdata, 0);
    chk("midrst_pwrite", pwrite, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_err", rsp_err, 0);
    chk("midrst_req_ready", req_ready, 1);
    repeat (3) begin
      @(negedge pclk);
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    t = '{wr: 1'b0, addr: 12'h010, wdata: 32'h0, rdata: 32'h0BAD_C0DE, waits: 2, serr: 1'b0};
    run_txn(t, 1, 1'b0, none);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      t.wr    = 1'($urandom);
      t.addr  = AW'($urandom);
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 4) : $urandom_range(0, 4);
      t.serr  = 1'($urandom);
      run_txn(t, $urandom_range(0, 3), 1'b0, none);
    end

    @(negedge pclk);
    req_valid = 1'b0;
    chk("end_idle", req_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-outstanding APB3 initiator that turns a valid/ready command stream into APB transfers toward peripheral register blocks, such as the GPIO register file, on the same `pclk`/`presetn` domain. It drives the SETUP and ACCESS phases and honours `pready`/`pslverr`. A programmable wait-state timeout ends transfers to slaves that never complete. It returns read data and error status on a valid/ready response stream.

## Interface
Parameters:
- `ADDR_W`, default 12: APB byte-address width.
- `TIMEOUT`, default 16: maximum ACCESS cycles without `pready` before abort. A value of 0 disables the timeout.

Ports:
- `pclk` input 1: clock, rising edge.
- `presetn` input 1: reset, synchronous, active-low.
- `req_valid` input 1: command valid.
- `req_ready` output 1: command accepted when high together with `req_valid`.
- `req_write` input 1: 1 selects write, 0 selects read.
- `req_addr` input ADDR_W: byte address. Bits [1:0] are forwarded unchanged.
- `req_wdata` input 32: write data.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumed.
- `rsp_rdata` output 32: read data. It is 0 for writes and for timeouts.
- `rsp_err` output 1: set by `pslverr` or by a timeout.
- `rsp_tmo` output 1: set by a timeout only.
- `psel` output 1: APB select.
- `penable` output 1: APB enable.
- `pwrite` output 1: APB direction.
- `paddr` output ADDR_W: APB address.
- `pwdata` output 32: APB write data.
- `prdata` input 32: APB read data.
- `pready` input 1: slave ready. Tie high for slaves that have no wait states.
- `pslverr` input 1: slave error.

## Operation
The block has four states: IDLE, SETUP, ACCESS and RESP. All outputs are registered, except `req_ready`, which equals (state == IDLE).

- **IDLE.** On `req_valid & req_ready`, latch `req_write`, `req_addr` and `req_wdata` into `pwrite`, `paddr` and `pwdata`, then go to SETUP.
- **SETUP.** Drive `psel` = 1 and `penable` = 0. Always move to ACCESS after one cycle.
- **ACCESS.** Drive `psel` = 1 and `penable` = 1.
  - If `pready` = 1, capture the result (`prdata` for reads, 0 for writes), set `rsp_err` = `pslverr` and `rsp_tmo` = 0, drop `psel` and `penable`, and go to RESP.
  - Otherwise increment the wait counter. When TIMEOUT ≠ 0 and the counter reaches TIMEOUT, set `rsp_rdata` = 0, `rsp_err` = 1 and `rsp_tmo` = 1, drop `psel` and `penable`, and go to RESP.
- **RESP.** Hold `rsp_valid` = 1 and keep the response stable until `rsp_ready`, then go to IDLE.

Rules that hold in every state:
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the last ACCESS cycle, and hold their last value while idle.
- The wait counter is cleared on entry to SETUP.
- The counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- `pslverr` is sampled only in an ACCESS cycle where `pready` = 1. It is ignored in every other cycle.
- Only one transfer is outstanding. No new command is accepted until the response handshake completes.

## Timing
- **Reset** (`presetn` low at a rising edge):
  - State returns to IDLE.
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err` and `rsp_tmo` = 0.
  - `paddr`, `pwdata` and `rsp_rdata` = 0.
  - `req_ready` = 1 from the first cycle after reset.
- **Reset mid-transfer.** The transfer is abandoned: `psel` and `penable` go low at that edge and no response is issued.
- **Zero-wait latency.** With the accept edge at cycle 0:
  - SETUP occupies cycle 1.
  - ACCESS occupies cycle 2.
  - `rsp_valid` rises at cycle 3.
  - With `rsp_ready` = 1, `req_ready` returns in cycle 4, so the minimum pitch is 4 cycles per transfer.
- **Wait states.** Each cycle with `pready` = 0 adds one ACCESS cycle.
- **Timeout.** With `pready` stuck low, ACCESS lasts exactly TIMEOUT cycles and `rsp_valid` rises on the next cycle.
- **Simultaneous `pready` and counter reaching TIMEOUT.** `pready` wins and the response is normal.
- **Response backpressure.** `rsp_valid` stays high for as many cycles as `rsp_ready` is low. APB stays idle, with `psel` = 0, during that time.

## Structure
- Package `apb_master_pkg` holds:
  - the state enum `apb_mst_state_t` (IDLE, SETUP, ACCESS, RESP);
  - the constant `APB_DATA_W` = 32;
  - the localparam rule for the timeout-counter width.
- One sub-module is natural: `apb_mst_tmo`, the wait counter.
  - Inputs: `clr`, `inc`.
  - Output: `expired`, asserted when count == TIMEOUT and TIMEOUT ≠ 0.
  - Same clock and synchronous reset as the parent.
- The FSM and the datapath live in `apb_cmd_master`.

## Test plan
- **Zero-wait write.** Write 0x0000_00A5 to address 0x000 with `pready` = 1. Require `psel` in cycles 1–2, `penable` in cycle 2 only, `pwdata` = 0xA5, `rsp_valid` at cycle 3 with `rsp_err` = 0 and `rsp_rdata` = 0.
- **Zero-wait read.** Read address 0x050 with the slave returning `prdata` = 0x0000_003C in ACCESS. Require `rsp_rdata` = 0x3C, `rsp_err` = 0, and `paddr` = 0x050 held stable through ACCESS.
- **Wait states and slave error.** Read with `pready` low for 3 ACCESS cycles, then high with `pslverr` = 1. Require 4 ACCESS cycles, `rsp_err` = 1, `rsp_tmo` = 0, and `pslverr` pulses during wait cycles ignored.
- **Timeout.** With TIMEOUT = 16 and `pready` stuck at 0, require exactly 16 ACCESS cycles followed by `rsp_valid` with `rsp_err` = 1, `rsp_tmo` = 1 and `rsp_rdata` = 0. Repeat with `pready` rising in ACCESS cycle 16 and require a normal response.
- **Backpressure and back-to-back commands.** Hold `rsp_ready` low for 5 cycles while `req_valid` stays high with the next command. Require `req_ready` = 0, `psel` = 0 and the response held stable throughout. The second command is accepted in the cycle after the response handshake.
- **Reset mid-ACCESS.** Assert `presetn` low during an ACCESS cycle. Require all outputs at their reset values on the next edge, no `rsp_valid`, and a clean transfer when a new command follows.
